// File: rtl/rv_dep_sc_rpt_arb.sv
//------------------------------------------------------------------------------
// Module  : rv_dep_sc_rpt_arb
// Brief   : Per-source report FIFOs drained round-robin onto the scorecard's
//           itag update ports, with zap flush and sticky overflow flag.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rv_dep_sc_rpt_arb #(
  parameter int NUM_SRC_G        = 4,
  parameter int NUM_PORT_G       = 2,
  parameter int FIFO_DEPTH_G     = 4,
  parameter int ITAG_WIDTH_ENC_G = 6
) (
  input  logic                                 nclk,
  input  logic                                 rst,
  input  logic                                 iu_xx_zap,
  input  logic [NUM_SRC_G-1:0]                 src_v,
  input  logic [NUM_SRC_G-1:0]                 src_abort,
  input  logic [NUM_SRC_G*ITAG_WIDTH_ENC_G-1:0] src_itag,
  output logic [NUM_SRC_G-1:0]                 src_hold,
  output logic [NUM_PORT_G-1:0]                out_v,
  output logic [NUM_PORT_G-1:0]                out_abort,
  output logic [NUM_PORT_G*ITAG_WIDTH_ENC_G-1:0] out_itag,
  output logic                                 ovf_err
);

  localparam int c_w     = ITAG_WIDTH_ENC_G;
  localparam int c_ptr_w = (FIFO_DEPTH_G > 1) ? $clog2(FIFO_DEPTH_G) : 1;
  localparam int c_cnt_w = $clog2(FIFO_DEPTH_G + 1);
  localparam int c_rr_w  = (NUM_SRC_G > 1) ? $clog2(NUM_SRC_G) : 1;

  // Entry layout: {abort, itag}
  logic [c_w:0]         r_mem   [NUM_SRC_G][FIFO_DEPTH_G];
  logic [c_ptr_w-1:0]   r_rd    [NUM_SRC_G];
  logic [c_ptr_w-1:0]   r_wr    [NUM_SRC_G];
  logic [c_cnt_w-1:0]   r_count [NUM_SRC_G];
  logic [c_rr_w-1:0]    r_rr;

  logic [NUM_SRC_G-1:0] w_push;
  logic [NUM_SRC_G-1:0] w_grant;
  logic [NUM_PORT_G-1:0] w_port_v;
  logic [c_rr_w-1:0]    w_port_src [NUM_PORT_G];
  logic [c_rr_w-1:0]    w_last;
  logic                 w_any;

  genvar gs;
  generate
    for (gs = 0; gs < NUM_SRC_G; gs++) begin : g_hold
      assign src_hold[gs] = (r_count[gs] == c_cnt_w'(FIFO_DEPTH_G));
    end
  endgenerate

  assign w_push = src_v & ~src_hold & {NUM_SRC_G{~iu_xx_zap}};

  // Scan from r_rr, handing the k-th non-empty source to port k.
  always_comb begin : arb
    int n;
    int idx;
    n        = 0;
    idx      = 0;
    w_grant  = '0;
    w_port_v = '0;
    w_last   = '0;
    w_any    = 1'b0;
    for (int k = 0; k < NUM_PORT_G; k++) begin
      w_port_src[k] = '0;
    end
    for (int i = 0; i < NUM_SRC_G; i++) begin
      idx = int'(r_rr) + i;
      if (idx >= NUM_SRC_G) idx = idx - NUM_SRC_G;
      if ((r_count[idx] != '0) && (n < NUM_PORT_G)) begin
        w_grant[idx]  = 1'b1;
        w_port_v[n]   = 1'b1;
        w_port_src[n] = c_rr_w'(idx);
        w_last        = c_rr_w'(idx);
        w_any         = 1'b1;
        n             = n + 1;
      end
    end
  end

  always_ff @(posedge nclk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SRC_G; s++) begin
        r_rd[s]    <= '0;
        r_wr[s]    <= '0;
        r_count[s] <= '0;
      end
      r_rr      <= '0;
      out_v     <= '0;
      out_abort <= '0;
      out_itag  <= '0;
      ovf_err   <= 1'b0;
    end else begin
      if (|(src_v & src_hold)) ovf_err <= 1'b1;
      if (iu_xx_zap) begin
        for (int s = 0; s < NUM_SRC_G; s++) begin
          r_rd[s]    <= '0;
          r_wr[s]    <= '0;
          r_count[s] <= '0;
        end
        r_rr      <= '0;
        out_v     <= '0;
        out_abort <= '0;
        out_itag  <= '0;
      end else begin
        for (int s = 0; s < NUM_SRC_G; s++) begin
          if (w_push[s]) begin
            r_mem[s][r_wr[s]] <= {src_abort[s], src_itag[s*c_w +: c_w]};
            r_wr[s]           <= r_wr[s] + 1'b1;
          end
          if (w_grant[s]) r_rd[s] <= r_rd[s] + 1'b1;
          if (w_push[s] && !w_grant[s])      r_count[s] <= r_count[s] + 1'b1;
          else if (!w_push[s] && w_grant[s]) r_count[s] <= r_count[s] - 1'b1;
        end
        for (int k = 0; k < NUM_PORT_G; k++) begin
          if (w_port_v[k]) begin
            out_v[k]               <= 1'b1;
            out_abort[k]           <= r_mem[w_port_src[k]][r_rd[w_port_src[k]]][c_w];
            out_itag[k*c_w +: c_w] <= r_mem[w_port_src[k]][r_rd[w_port_src[k]]][c_w-1:0];
          end else begin
            out_v[k]               <= 1'b0;
            out_abort[k]           <= 1'b0;
            out_itag[k*c_w +: c_w] <= '0;
          end
        end
        if (w_any) begin
          r_rr <= (w_last == c_rr_w'(NUM_SRC_G - 1)) ? '0 : w_last + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rv_dep_sc_rpt_arb.sv
//------------------------------------------------------------------------------
// Module  : tb_rv_dep_sc_rpt_arb
// Brief   : Randomized scoreboard bench with a queue-based reference model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_rv_dep_sc_rpt_arb;

  localparam int S = 4;
  localparam int P = 2;
  localparam int D = 4;
  localparam int W = 6;

  logic             nclk = 1'b0;
  logic             rst = 1'b0;
  logic             iu_xx_zap = 1'b0;
  logic [S-1:0]     src_v = '0;
  logic [S-1:0]     src_abort = '0;
  logic [S*W-1:0]   src_itag = '0;
  logic [S-1:0]     src_hold;
  logic [P-1:0]     out_v;
  logic [P-1:0]     out_abort;
  logic [P*W-1:0]   out_itag;
  logic             ovf_err;

  always #5 nclk = ~nclk;

  rv_dep_sc_rpt_arb #(
    .NUM_SRC_G(S), .NUM_PORT_G(P), .FIFO_DEPTH_G(D), .ITAG_WIDTH_ENC_G(W)
  ) dut (
    .nclk(nclk), .rst(rst), .iu_xx_zap(iu_xx_zap),
    .src_v(src_v), .src_abort(src_abort), .src_itag(src_itag),
    .src_hold(src_hold), .out_v(out_v), .out_abort(out_abort),
    .out_itag(out_itag), .ovf_err(ovf_err)
  );

  typedef struct {
    int           cyc;
    logic [P-1:0] v;
    logic [P-1:0] a;
    logic [P*W-1:0] itag;
    logic [S-1:0] hold;
    logic         ovf;
  } exp_t;

  typedef logic [W:0] ent_q_t[$];

  exp_t   exp_q[$];
  ent_q_t mq[S];
  int     m_rr = 0;
  logic   m_ovf = 1'b0;
  int     cyc = 0;
  int     n_cmp = 0;
  int     n_bad = 0;

  always @(posedge nclk) cyc = cyc + 1;

  // One cycle of stimulus; the model predicts what is visible after the edge.
  task automatic step(input logic [S-1:0] v, input logic [S-1:0] a,
                      input logic [S*W-1:0] it, input logic z, input logic r);
    exp_t e;
    logic [S-1:0] hold_pre;
    logic [W:0] ent;
    int n;
    int s;
    int last;
    @(posedge nclk);
    #1;
    src_v = v; src_abort = a; src_itag = it; iu_xx_zap = z; rst = r;
    for (int i = 0; i < S; i++) hold_pre[i] = (mq[i].size() == D);
    e.cyc = cyc + 1; e.v = '0; e.a = '0; e.itag = '0;
    if (r) begin
      for (int i = 0; i < S; i++) mq[i].delete();
      m_rr = 0; m_ovf = 1'b0;
    end else begin
      if (|(v & hold_pre)) m_ovf = 1'b1;
      if (z) begin
        for (int i = 0; i < S; i++) mq[i].delete();
        m_rr = 0;
      end else begin
        n = 0; last = 0;
        for (int i = 0; i < S; i++) begin
          s = (m_rr + i) % S;
          if (n < P && mq[s].size() > 0) begin
            ent = mq[s].pop_front();
            e.v[n] = 1'b1;
            e.a[n] = ent[W];
            e.itag[n*W +: W] = ent[W-1:0];
            last = s;
            n++;
          end
        end
        if (n > 0) m_rr = (last + 1) % S;
        for (int i = 0; i < S; i++)
          if (v[i] && !hold_pre[i]) mq[i].push_back({a[i], it[i*W +: W]});
      end
    end
    for (int i = 0; i < S; i++) e.hold[i] = (mq[i].size() == D);
    e.ovf = m_ovf;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0, 1'b0, 1'b0);
  endtask

  function automatic logic [S-1:0] model_hold();
    logic [S-1:0] h;
    for (int i = 0; i < S; i++) h[i] = (mq[i].size() == D);
    return h;
  endfunction

  // Monitor: compares the DUT against whichever prediction is due this cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge nclk);
      #3;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (out_v !== e.v || out_abort !== e.a || out_itag !== e.itag ||
            src_hold !== e.hold || ovf_err !== e.ovf) begin
          n_bad++;
          $display("FAIL outputs cyc=%0d: got v=%b a=%b itag=%h hold=%b ovf=%b, want v=%b a=%b itag=%h hold=%b ovf=%b",
                   cyc, out_v, out_abort, out_itag, src_hold, ovf_err,
                   e.v, e.a, e.itag, e.hold, e.ovf);
        end
      end
    end
  end

  initial begin : stim
    logic [S-1:0]   v;
    logic [S*W-1:0] it;
    int             wait_cnt;

    step('0, '0, '0, 1'b0, 1'b1);
    step('0, '0, '0, 1'b0, 1'b1);
    idle(2);

    // Single report from source 1
    it = '0; it[1*W +: W] = 6'd5;
    step(4'b0010, 4'b0000, it, 1'b0, 1'b0);
    idle(3);

    // All sources at once, two ports
    step(4'b1111, 4'b0101, {6'd4, 6'd3, 6'd2, 6'd1}, 1'b0, 1'b0);
    idle(4);

    // Random traffic that honours hold
    for (int i = 0; i < 200; i++) begin
      v  = 4'($urandom) & ~model_hold();
      it = 24'($urandom);
      step(v, 4'($urandom), it, 1'b0, 1'b0);
    end
    idle(6);

    // Sources 0-2 saturating, source 3 idle
    for (int i = 0; i < 30; i++) step(4'b0111 & ~model_hold(), 4'($urandom), 24'($urandom), 1'b0, 1'b0);
    idle(8);

    // Push ignoring hold to provoke overflow
    for (int i = 0; i < 20; i++) step(4'b1111, 4'($urandom), 24'($urandom), 1'b0, 1'b0);
    idle(8);

    // Zap with queued entries and pushes in the zap cycle
    step(4'b0111, 4'b0010, 24'($urandom), 1'b0, 1'b0);
    step(4'b1111, 4'b1111, 24'($urandom), 1'b1, 1'b0);
    idle(4);

    // Random mix with occasional zaps and hold violations
    for (int i = 0; i < 200; i++) begin
      v = 4'($urandom);
      if ($urandom_range(0, 3) != 0) v = v & ~model_hold();
      step(v, 4'($urandom), 24'($urandom), ($urandom_range(0, 15) == 0), 1'b0);
    end

    // Reset mid-stream with full FIFOs and overflow set
    for (int i = 0; i < 8; i++) step(4'b1111, 4'($urandom), 24'($urandom), 1'b0, 1'b0);
    step(4'b1111, 4'($urandom), 24'($urandom), 1'b1, 1'b1);
    it = '0; it[2*W +: W] = 6'd42;
    step(4'b0100, 4'b0100, it, 1'b0, 1'b0);
    idle(5);

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge nclk);
      wait_cnt++;
    end
    #5;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d predictions left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
